// File: rtl/mlp_sample_sequencer.sv
// Feeds a combinational printed-MLP classifier: packs NUM_A serial features into its input bus,
// waits a settle window, then captures the class code onto a valid/ready result port.
module mlp_sample_sequencer #(
    parameter int unsigned NUM_A         = 11,
    parameter int unsigned WIDTH_A       = 4,
    parameter int unsigned OUTWIDTH      = 3,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       feat_valid,
    output logic                       feat_ready,
    input  logic [WIDTH_A-1:0]         feat_data,
    input  logic                       feat_last,
    output logic [NUM_A*WIDTH_A-1:0]   inp,
    input  logic [OUTWIDTH-1:0]        out_cls,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [OUTWIDTH-1:0]        res_class,
    output logic                       res_err
);

    localparam int unsigned IdxW = (NUM_A > 1) ? $clog2(NUM_A) : 1;
    localparam int unsigned CntW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_A - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {StLoad, StSettle, StResult} state_e;

    state_e                     state_q, state_d;
    logic [IdxW-1:0]            idx_q, idx_d;
    logic [CntW-1:0]            cnt_q, cnt_d;
    logic [NUM_A*WIDTH_A-1:0]   inp_q, inp_d;
    logic                       res_valid_q, res_valid_d;
    logic [OUTWIDTH-1:0]        res_class_q, res_class_d;
    logic                       res_err_q, res_err_d;
    logic                       err_q, err_d;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        inp_d       = inp_q;
        res_valid_d = res_valid_q;
        res_class_d = res_class_q;
        res_err_d   = res_err_q;
        err_d       = err_q;
        feat_ready  = 1'b0;

        unique case (state_q)
            StLoad: begin
                feat_ready = 1'b1;
                if (feat_valid) begin
                    inp_d[int'(idx_q)*WIDTH_A +: WIDTH_A] = feat_data;
                    // feat_last only flags framing; sample length is fixed at NUM_A
                    err_d = err_q | (feat_last != (idx_q == LastIdx));
                    if (idx_q == LastIdx) begin
                        idx_d   = '0;
                        cnt_d   = '0;
                        state_d = StSettle;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StSettle: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    res_class_d = out_cls;
                    res_err_d   = err_q;
                    err_d       = 1'b0;
                    res_valid_d = 1'b1;
                    state_d     = StResult;
                end
            end
            StResult: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = StLoad;
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StLoad;
            idx_q       <= '0;
            cnt_q       <= '0;
            inp_q       <= '0;
            res_valid_q <= 1'b0;
            res_class_q <= '0;
            res_err_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            inp_q       <= inp_d;
            res_valid_q <= res_valid_d;
            res_class_q <= res_class_d;
            res_err_q   <= res_err_d;
            err_q       <= err_d;
        end
    end

    assign inp       = inp_q;
    assign res_valid = res_valid_q;
    assign res_class = res_class_q;
    assign res_err   = res_err_q;

endmodule

// File: tb/tb_mlp_sample_sequencer.sv
// Directed bench for mlp_sample_sequencer; a stub classifier drives out_cls from inp[2:0].
module tb_mlp_sample_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        feat_valid;
    logic        feat_ready;
    logic [3:0]  feat_data;
    logic        feat_last;
    logic [43:0] inp;
    logic [2:0]  out_cls;
    logic        res_valid;
    logic        res_ready;
    logic [2:0]  res_class;
    logic        res_err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    assign out_cls = inp[2:0];

    mlp_sample_sequencer #(
        .NUM_A        (11),
        .WIDTH_A      (4),
        .OUTWIDTH     (3),
        .SETTLE_CYCLES(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .feat_valid(feat_valid),
        .feat_ready(feat_ready),
        .feat_data (feat_data),
        .feat_last (feat_last),
        .inp       (inp),
        .out_cls   (out_cls),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_class (res_class),
        .res_err   (res_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns just after the edge that accepts the feature.
    task automatic send_feat(input logic [3:0] d, input logic last);
        int waited = 0;
        feat_valid = 1'b1;
        feat_data  = d;
        feat_last  = last;
        while (!feat_ready && waited < 50) begin
            step();
            waited++;
        end
        if (!feat_ready) begin
            total_cnt++;
            $display("FAIL send_timeout: feat_ready=%0b after %0d cycles, required 1", feat_ready,
                     waited);
        end else begin
            step();
        end
        feat_valid = 1'b0;
        feat_last  = 1'b0;
    endtask

    task automatic send_sample(input logic [43:0] vec, input int last_pos, input int gap_max);
        for (int k = 0; k < 11; k++) begin
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) step();
            send_feat(vec[k*4 +: 4], (k == last_pos));
        end
    endtask

    // Latency counts edges from the last accept edge (=1) to the edge raising res_valid.
    task automatic wait_result(output int lat);
        lat = 1;
        while (!res_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic release_result();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        feat_valid = 1'b1;
        feat_data  = 4'hF;
        feat_last  = 1'b0;
        res_ready  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total_cnt++;
            if (inp !== 44'h0) $display("FAIL rst_inp: got %h, required 0", inp);
            else pass_cnt++;
            total_cnt++;
            if (res_valid !== 1'b0) $display("FAIL rst_res_valid: got %b, required 0", res_valid);
            else pass_cnt++;
            total_cnt++;
            if (res_class !== 3'd0) $display("FAIL rst_res_class: got %0d, required 0", res_class);
            else pass_cnt++;
            total_cnt++;
            if (res_err !== 1'b0) $display("FAIL rst_res_err: got %b, required 0", res_err);
            else pass_cnt++;
        end
        rst        = 1'b0;
        feat_valid = 1'b0;
        step();
        total_cnt++;
        if (feat_ready !== 1'b1) $display("FAIL rst_feat_ready: got %b, required 1", feat_ready);
        else pass_cnt++;
    endtask

    task automatic test_nominal();
        int lat;
        send_sample(44'h0BA987654321, 10, 0);
        wait_result(lat);
        total_cnt++;
        if (lat !== 5) $display("FAIL nom_latency: got %0d, required 5", lat);
        else pass_cnt++;
        total_cnt++;
        if (inp !== 44'h0BA987654321) $display("FAIL nom_inp: got %h, required 0ba987654321", inp);
        else pass_cnt++;
        total_cnt++;
        if (res_class !== 3'd1) $display("FAIL nom_class: got %0d, required 1", res_class);
        else pass_cnt++;
        total_cnt++;
        if (res_err !== 1'b0) $display("FAIL nom_err: got %b, required 0", res_err);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        feat_valid = 1'b1;
        feat_data  = 4'hF;
        feat_last  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            total_cnt++;
            if (res_valid !== 1'b1) $display("FAIL bp_valid: got %b, required 1", res_valid);
            else pass_cnt++;
            total_cnt++;
            if (res_class !== 3'd1) $display("FAIL bp_class: got %0d, required 1", res_class);
            else pass_cnt++;
            total_cnt++;
            if (feat_ready !== 1'b0) $display("FAIL bp_feat_ready: got %b, required 0", feat_ready);
            else pass_cnt++;
            total_cnt++;
            if (inp !== 44'h0BA987654321)
                $display("FAIL bp_inp: got %h, required 0ba987654321", inp);
            else pass_cnt++;
        end
        feat_valid = 1'b0;
        feat_last  = 1'b0;
        release_result();
        total_cnt++;
        if (res_valid !== 1'b0) $display("FAIL bp_clear: got %b, required 0", res_valid);
        else pass_cnt++;
        total_cnt++;
        if (feat_ready !== 1'b1) $display("FAIL bp_ready_back: got %b, required 1", feat_ready);
        else pass_cnt++;
    endtask

    task automatic test_gapped();
        int lat;
        send_sample(44'h0BA987654321, 10, 3);
        wait_result(lat);
        total_cnt++;
        if (lat !== 5) $display("FAIL gap_latency: got %0d, required 5", lat);
        else pass_cnt++;
        total_cnt++;
        if (inp !== 44'h0BA987654321) $display("FAIL gap_inp: got %h, required 0ba987654321", inp);
        else pass_cnt++;
        total_cnt++;
        if (res_class !== 3'd1) $display("FAIL gap_class: got %0d, required 1", res_class);
        else pass_cnt++;
        release_result();
    endtask

    task automatic test_framing();
        int lat;
        send_sample(44'h0123456789A, 4, 0);
        wait_result(lat);
        total_cnt++;
        if (lat !== 5) $display("FAIL frm_latency: got %0d, required 5", lat);
        else pass_cnt++;
        total_cnt++;
        if (res_err !== 1'b1) $display("FAIL frm_err: got %b, required 1", res_err);
        else pass_cnt++;
        total_cnt++;
        if (res_class !== 3'd2) $display("FAIL frm_class: got %0d, required 2", res_class);
        else pass_cnt++;
        total_cnt++;
        if (inp !== 44'h0123456789A) $display("FAIL frm_inp: got %h, required 0123456789a", inp);
        else pass_cnt++;
        release_result();
        send_sample(44'h05555555557, 10, 0);
        wait_result(lat);
        total_cnt++;
        if (res_err !== 1'b0) $display("FAIL frm_clean_err: got %b, required 0", res_err);
        else pass_cnt++;
        total_cnt++;
        if (res_class !== 3'd7) $display("FAIL frm_clean_class: got %0d, required 7", res_class);
        else pass_cnt++;
        release_result();
    endtask

    task automatic test_back_to_back();
        logic [43:0] vecs [3];
        logic [2:0]  exp_cls [3];
        int          t [3];
        logic [2:0]  cls [3];
        logic        err [3];
        logic [43:0] snap [3];
        int          n = 0;

        vecs[0] = 44'h0FEDCBA9879; exp_cls[0] = 3'd1;
        vecs[1] = 44'h0ABCDEF1236; exp_cls[1] = 3'd6;
        vecs[2] = 44'h0777777777D; exp_cls[2] = 3'd5;
        for (int i = 0; i < 3; i++) begin
            t[i] = 0; cls[i] = '0; err[i] = 1'b1; snap[i] = '0;
        end

        for (int k = 0; k < 6; k++) send_feat(4'hE, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        total_cnt++;
        if (inp !== 44'h0) $display("FAIL mid_rst_inp: got %h, required 0", inp);
        else pass_cnt++;
        total_cnt++;
        if (feat_ready !== 1'b1) $display("FAIL mid_rst_ready: got %b, required 1", feat_ready);
        else pass_cnt++;

        res_ready = 1'b1;
        fork
            begin
                for (int s = 0; s < 3; s++) send_sample(vecs[s], 10, 0);
            end
            begin
                for (int c = 1; c <= 80; c++) begin
                    step();
                    if (res_valid) begin
                        if (n < 3) begin
                            t[n] = c; cls[n] = res_class; err[n] = res_err; snap[n] = inp;
                        end
                        n++;
                    end
                end
            end
        join
        res_ready = 1'b0;

        total_cnt++;
        if (n !== 3) $display("FAIL b2b_count: got %0d results, required 3", n);
        else pass_cnt++;
        total_cnt++;
        if (t[0] !== 15) $display("FAIL b2b_first_cycle: got %0d, required 15", t[0]);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (cls[i] !== exp_cls[i])
                $display("FAIL b2b_class[%0d]: got %0d, required %0d", i, cls[i], exp_cls[i]);
            else pass_cnt++;
            total_cnt++;
            if (err[i] !== 1'b0) $display("FAIL b2b_err[%0d]: got %b, required 0", i, err[i]);
            else pass_cnt++;
            total_cnt++;
            if (snap[i] !== vecs[i])
                $display("FAIL b2b_inp[%0d]: got %h, required %h", i, snap[i], vecs[i]);
            else pass_cnt++;
        end
        for (int i = 1; i < 3; i++) begin
            total_cnt++;
            if (t[i] - t[i-1] !== 16)
                $display("FAIL b2b_period[%0d]: got %0d, required 16", i, t[i] - t[i-1]);
            else pass_cnt++;
        end
    endtask

    initial begin
        rst        = 1'b1;
        feat_valid = 1'b0;
        feat_data  = '0;
        feat_last  = 1'b0;
        res_ready  = 1'b0;
        test_reset();
        test_nominal();
        test_backpressure();
        test_gapped();
        test_framing();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
